// File: rtl/bbox_pkg.sv
// Shared types and constants for the star bounding-box sequencer.
// Contents: sequencer state encoding, error codes, default coordinate width.
package bbox_pkg;

    localparam int unsigned DEFAULT_COORD_W = 3;
    localparam int unsigned ERR_W           = 2;

    typedef enum logic [2:0] {
        IDLE,
        TB_START,
        TB_WAIT,
        LR_ARM,
        LR_WAIT,
        CHECK,
        OUTPUT
    } seqState_t;

    localparam logic [ERR_W-1:0] ERR_OK   = ERR_W'(0);
    localparam logic [ERR_W-1:0] ERR_TB   = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_LR   = ERR_W'(2);
    localparam logic [ERR_W-1:0] ERR_GEOM = ERR_W'(3);

endpackage

// File: rtl/phase_timer.sv
// Per-phase watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT-1.
// Ports: clk, resetn (sync, active-low), clear, enable, expired.
module phase_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Saturates at LAST so a phase that lingers never wraps the count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/bbox_sequencer.sv
// Frame-level controller for the star bounding-box pipeline: runs the
// top/bottom finder, launches both edge scanners, gathers their results,
// checks geometry and hands one bounding box per frame to a valid/ready sink.
// Ports: clk/resetn; start/busy; tb_start, tb_done, tb_top/bottom/mid to the
// top/bottom finder; lr_go, lr_top/bottom/mid, left/right_found,
// most_left/right to the edge scanners; bbox_valid/ready, bbox_* and err_code
// on the result side.
module bbox_sequencer
    import bbox_pkg::*;
#(
    parameter int unsigned COORD_W = DEFAULT_COORD_W,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    output logic               busy,
    output logic               tb_start,
    input  logic               tb_done,
    input  logic [COORD_W-1:0] tb_top,
    input  logic [COORD_W-1:0] tb_bottom,
    input  logic [COORD_W-1:0] tb_mid,
    output logic               lr_go,
    output logic [COORD_W-1:0] lr_top,
    output logic [COORD_W-1:0] lr_bottom,
    output logic [COORD_W-1:0] lr_mid,
    input  logic               left_found,
    input  logic               right_found,
    input  logic [COORD_W-1:0] most_left,
    input  logic [COORD_W-1:0] most_right,
    output logic               bbox_valid,
    input  logic               bbox_ready,
    output logic [COORD_W-1:0] bbox_top,
    output logic [COORD_W-1:0] bbox_bottom,
    output logic [COORD_W-1:0] bbox_left,
    output logic [COORD_W-1:0] bbox_right,
    output logic [ERR_W-1:0]   err_code
);

    seqState_t          state;
    logic               blank;      // first cycle of a wait phase
    logic               lCap;
    logic               rCap;
    logic [COORD_W-1:0] leftVal;
    logic [COORD_W-1:0] rightVal;

    logic               leftHit;
    logic               rightHit;
    logic               lDone;
    logic               rDone;
    logic [COORD_W-1:0] leftNext;
    logic [COORD_W-1:0] rightNext;
    logic               geomBad;
    logic               timerClear;
    logic               timerEnable;
    logic               expired;

    // Capture qualification, geometry check and watchdog control.
    always_comb begin
        leftHit     = (state == LR_WAIT) && !blank && !lCap && left_found;
        rightHit    = (state == LR_WAIT) && !blank && !rCap && right_found;
        lDone       = lCap || leftHit;
        rDone       = rCap || rightHit;
        leftNext    = lCap ? leftVal : most_left;
        rightNext   = rCap ? rightVal : most_right;
        geomBad     = (lr_top > lr_bottom) || (leftVal > lr_mid) || (lr_mid > rightVal);
        timerClear  = (state == TB_START) || (state == LR_ARM);
        timerEnable = (state == TB_WAIT) || (state == LR_WAIT);
    end

    phase_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (timerClear),
        .enable  (timerEnable),
        .expired (expired)
    );

    // Sequencer FSM with registered outputs and capture registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            blank       <= 1'b0;
            lCap        <= 1'b0;
            rCap        <= 1'b0;
            leftVal     <= '0;
            rightVal    <= '0;
            busy        <= 1'b0;
            tb_start    <= 1'b0;
            lr_go       <= 1'b0;
            lr_top      <= '0;
            lr_bottom   <= '0;
            lr_mid      <= '0;
            bbox_valid  <= 1'b0;
            bbox_top    <= '0;
            bbox_bottom <= '0;
            bbox_left   <= '0;
            bbox_right  <= '0;
            err_code    <= ERR_OK;
        end else begin
            tb_start <= 1'b0;
            lr_go    <= 1'b0;
            blank    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= TB_START;
                        tb_start <= 1'b1;
                        busy     <= 1'b1;
                        lCap     <= 1'b0;
                        rCap     <= 1'b0;
                    end
                end
                TB_START: begin
                    state <= TB_WAIT;
                    blank <= 1'b1;
                end
                TB_WAIT: begin
                    if (!blank && tb_done) begin
                        lr_top    <= tb_top;
                        lr_bottom <= tb_bottom;
                        lr_mid    <= tb_mid;
                        lr_go     <= 1'b1;
                        state     <= LR_ARM;
                    end else if (expired) begin
                        // No fresh seeds: report the previously held ones.
                        err_code    <= ERR_TB;
                        bbox_top    <= lr_top;
                        bbox_bottom <= lr_bottom;
                        bbox_left   <= lr_mid;
                        bbox_right  <= lr_mid;
                        bbox_valid  <= 1'b1;
                        state       <= OUTPUT;
                    end
                end
                LR_ARM: begin
                    state <= LR_WAIT;
                    blank <= 1'b1;
                end
                LR_WAIT: begin
                    if (leftHit) begin
                        lCap    <= 1'b1;
                        leftVal <= most_left;
                    end
                    if (rightHit) begin
                        rCap     <= 1'b1;
                        rightVal <= most_right;
                    end
                    if (lDone && rDone) begin
                        state <= CHECK;
                    end else if (expired) begin
                        // Missing side falls back to the row seed.
                        err_code    <= ERR_LR;
                        bbox_top    <= lr_top;
                        bbox_bottom <= lr_bottom;
                        bbox_left   <= lDone ? leftNext : lr_mid;
                        bbox_right  <= rDone ? rightNext : lr_mid;
                        bbox_valid  <= 1'b1;
                        state       <= OUTPUT;
                    end
                end
                CHECK: begin
                    err_code    <= geomBad ? ERR_GEOM : ERR_OK;
                    bbox_top    <= lr_top;
                    bbox_bottom <= lr_bottom;
                    bbox_left   <= leftVal;
                    bbox_right  <= rightVal;
                    bbox_valid  <= 1'b1;
                    state       <= OUTPUT;
                end
                OUTPUT: begin
                    if (bbox_ready) begin
                        bbox_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
